// File: rtl/ram512_loader.sv
// ram512_loader: write sequencer that fills ram512 from a little-endian byte
// stream (two bytes per word, sequential addresses from a base) or zero-fills
// the whole RAM. Every output is a flop, so ram512 sees clean, glitch-free
// value/load/address lines.
module ram512_loader #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [WIDTH-1:0]      value,
  output logic                  load,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_WIDTH:0]   DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]      value_q, value_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  load_q, load_d;
  logic                  busy_q, busy_d;
  logic                  byte_ready_q, byte_ready_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH:0]   len_clamped;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic                  handshake;

  // Clamp the requested length, wrap the pointer modulo DEPTH, detect a byte transfer
  always_comb begin
    len_clamped = (length > DEPTH_C) ? DEPTH_C : length;
    ptr_inc     = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
    handshake   = byte_valid && byte_ready_q;
  end

  // Next-state and datapath; outputs are derived from the state being entered
  // so that each registered output lines up with the state it belongs to
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    remaining_d  = remaining_q;
    value_d      = value_q;
    address_d    = address_q;
    word_count_d = word_count_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d        = start_addr;
          remaining_d  = len_clamped;
          word_count_d = '0;
          state_d      = (len_clamped == '0) ? S_DONE : S_LOW;
        end else if (clear) begin
          ptr_d        = '0;
          word_count_d = '0;
          address_d    = '0;
          value_d      = '0;
          state_d      = S_CLEAR;
        end
      end
      S_LOW: begin
        if (handshake) begin
          value_d = {value_q[WIDTH-1:8], byte_in};
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (handshake) begin
          value_d   = {byte_in, value_q[7:0]};
          address_d = ptr_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        // ram512 captures value/address on the edge leaving this state
        ptr_d        = ptr_inc;
        word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
        remaining_d  = remaining_q - (ADDR_WIDTH + 1)'(1);
        state_d      = (remaining_q == (ADDR_WIDTH + 1)'(1)) ? S_DONE : S_LOW;
      end
      S_CLEAR: begin
        // address_q is the word being zeroed this cycle
        word_count_d = word_count_q + (ADDR_WIDTH + 1)'(1);
        value_d      = '0;
        ptr_d        = ptr_inc;
        if (address_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          address_d = address_q + ADDR_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    load_d       = (state_d == S_WRITE) || (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE);
    byte_ready_d = (state_d == S_LOW) || (state_d == S_HIGH);
    done_d       = (state_d == S_DONE);
  end

  // State and output registers; reset discards any half-assembled word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      remaining_q  <= '0;
      value_q      <= '0;
      address_q    <= '0;
      word_count_q <= '0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      remaining_q  <= remaining_d;
      value_q      <= value_d;
      address_q    <= address_d;
      word_count_q <= word_count_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      byte_ready_q <= byte_ready_d;
      done_q       <= done_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign value      = value_q;
  assign load       = load_q;
  assign address    = address_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_count = word_count_q;

endmodule
